// File: rtl/amm2amm_pipe.sv
// Avalon-MM pipeline bridge: posted writes and blocking reads through a command FIFO.
// Define AMM2AMM_PIPE_TIMEOUT_EN to abort reads stalled for P_TIMEOUT cycles.
module amm2amm_pipe #(
    parameter int P_AW      = 32,
    parameter int P_DW      = 32,
    parameter int P_DEPTH   = 4,
    parameter int P_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [P_AW-1:0]     s_address,
    input  logic [P_DW/8-1:0]   s_byteenable,
    input  logic [P_DW-1:0]     s_writedata,
    input  logic                s_read,
    input  logic                s_write,
    output logic                s_waitrequest,
    output logic [P_DW-1:0]     s_readdata,
    output logic [P_AW-1:0]     m_address,
    output logic [P_DW/8-1:0]   m_byteenable,
    output logic [P_DW-1:0]     m_writedata,
    output logic                m_read,
    output logic                m_write,
    input  logic                m_waitrequest,
    input  logic [P_DW-1:0]     m_readdata,
    output logic                timeout
);
    localparam int PW = $clog2(P_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = P_DW / 8;

    if ((P_DW % 8) != 0 || P_DEPTH < 2 || (1 << PW) != P_DEPTH ||
        P_TIMEOUT < 1 || P_TIMEOUT > 65535) begin : g_param_check
        $error("amm2amm_pipe: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_e;

    typedef struct packed {
        logic            rd;
        logic            wr;
        logic [P_AW-1:0] addr;
        logic [BW-1:0]   be;
        logic [P_DW-1:0] wdata;
    } entry_t;

    entry_t          mem_q [P_DEPTH];
    entry_t          head;
    entry_t          push_entry;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    state_e          state_q, state_d;
    logic [P_DW-1:0] rdata_q, rdata_d;
    logic            full, empty, push, pop, tmo_hit;

    // Full comes from the registered count only, so m_waitrequest never reaches s_waitrequest.
    assign full  = (count_q == CW'(P_DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    assign push_entry.rd    = ~s_write;
    assign push_entry.wr    = s_write;
    assign push_entry.addr  = s_address;
    assign push_entry.be    = s_byteenable;
    assign push_entry.wdata = s_writedata;

    assign m_address    = head.addr;
    assign m_byteenable = head.be;
    assign m_writedata  = head.wdata;
    assign m_read       = ~reset & ~empty & head.rd;
    assign m_write      = ~reset & ~empty & head.wr;
    assign pop          = ((m_read | m_write) & ~m_waitrequest) | tmo_hit;
    assign s_readdata   = rdata_q;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        rdata_d       = rdata_q;
        push          = 1'b0;
        s_waitrequest = 1'b1;
        case (state_q)
            IDLE: begin
                if (s_write) begin
                    s_waitrequest = full;
                    push          = ~full;
                end else if (s_read && !full) begin
                    push    = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Pushes are frozen here, so a popped read entry is always this read.
                if (pop && head.rd) begin
                    rdata_d = tmo_hit ? '1 : m_readdata;
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                s_waitrequest = s_write;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            s_waitrequest = 1'b1;
            push          = 1'b0;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: sequential state is assigned with non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
        end
    end

    // NOTE: the storage array is not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

`ifdef AMM2AMM_PIPE_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_q;
    logic        stalled;

    assign stalled = (state_q == RD_WAIT) & m_read & m_waitrequest;
    assign tmo_hit = stalled & (tmo_cnt_q == 16'(P_TIMEOUT));
    assign timeout = tmo_q & ~reset;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (pop) begin
            tmo_cnt_d = '0;
        end else if (stalled) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_amm2amm_pipe.sv
// Self-checking bench for amm2amm_pipe: directed vector table, reset/timeout sequences,
// and randomized traffic against a transaction-level memory and ordering model.
module tb_amm2amm_pipe;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] s_address;
    logic [BW-1:0] s_byteenable;
    logic [DW-1:0] s_writedata;
    logic          s_read, s_write, s_waitrequest;
    logic [DW-1:0] s_readdata;
    logic [AW-1:0] m_address;
    logic [BW-1:0] m_byteenable;
    logic [DW-1:0] m_writedata;
    logic          m_read, m_write, m_waitrequest;
    logic [DW-1:0] m_readdata;
    logic          timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    amm2amm_pipe #(.P_AW(AW), .P_DW(DW), .P_DEPTH(DEPTH), .P_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata),
        .m_address(m_address), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .timeout(timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, return at the falling edge.
    task automatic cycle(input logic rst, input logic sw, input logic sr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic mw, input logic [31:0] mrd);
        @(posedge clk);
        #1;
        reset         = rst;
        s_write       = sw;
        s_read        = sr;
        s_address     = addr;
        s_writedata   = wdata;
        s_byteenable  = 4'hF;
        m_waitrequest = mw;
        m_readdata    = mrd;
        @(negedge clk);
    endtask

    typedef struct {
        logic        sw, sr;
        logic [31:0] addr, wdata;
        logic        mw;
        logic [31:0] mrd;
        logic        e_sw, e_mwr, e_mrd;
        logic [31:0] e_maddr, e_mwdata;
        logic        chk_srd;
        logic [31:0] e_srd;
    } vec_t;

    function automatic vec_t mk(logic sw, logic sr, logic [31:0] addr, logic [31:0] wdata,
                                logic mw, logic [31:0] mrd, logic e_sw, logic e_mwr,
                                logic e_mrd, logic [31:0] e_maddr, logic [31:0] e_mwdata,
                                logic chk_srd, logic [31:0] e_srd);
        vec_t v;
        v.sw = sw; v.sr = sr; v.addr = addr; v.wdata = wdata; v.mw = mw; v.mrd = mrd;
        v.e_sw = e_sw; v.e_mwr = e_mwr; v.e_mrd = e_mrd; v.e_maddr = e_maddr;
        v.e_mwdata = e_mwdata; v.chk_srd = chk_srd; v.e_srd = e_srd;
        return v;
    endfunction

    typedef struct {
        logic        rd;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
    } cmd_t;

    vec_t        tbl [13];
    cmd_t        exp_q [$];
    cmd_t        cmd, got;
    logic [31:0] ref_mem [8];
    logic [31:0] slv_mem [8];
    logic [31:0] up;
    int          r, idx, pend_age, stall_run, lows, pulses;
    bit          pend, found;

    initial begin
        reset = 1'b1; s_write = 0; s_read = 0; s_address = 0; s_writedata = 0;
        s_byteenable = 0; m_waitrequest = 1; m_readdata = 0;

        // Fill list: back-to-back writes into a stalled master, then write-before-read ordering.
        tbl[0]  = mk(1, 0, 32'h10, 32'hA0, 1, 0,    0, 0, 0, 0,     0,     0, 0);
        tbl[1]  = mk(1, 0, 32'h14, 32'hA1, 1, 0,    0, 1, 0, 32'h10, 32'hA0, 0, 0);
        tbl[2]  = mk(1, 0, 32'h18, 32'hA2, 1, 0,    0, 1, 0, 32'h10, 32'hA0, 0, 0);
        tbl[3]  = mk(1, 0, 32'h1C, 32'hA3, 1, 0,    0, 1, 0, 32'h10, 32'hA0, 0, 0);
        tbl[4]  = mk(1, 0, 32'h20, 32'h55, 1, 0,    1, 1, 0, 32'h10, 32'hA0, 0, 0);
        tbl[5]  = mk(1, 0, 32'h20, 32'h55, 0, 0,    1, 1, 0, 32'h10, 32'hA0, 0, 0);
        tbl[6]  = mk(1, 0, 32'h20, 32'h55, 0, 0,    0, 1, 0, 32'h14, 32'hA1, 0, 0);
        tbl[7]  = mk(0, 1, 32'h20, 0,      0, 0,    1, 1, 0, 32'h18, 32'hA2, 0, 0);
        tbl[8]  = mk(0, 1, 32'h20, 0,      0, 0,    1, 1, 0, 32'h1C, 32'hA3, 0, 0);
        tbl[9]  = mk(0, 1, 32'h20, 0,      0, 0,    1, 1, 0, 32'h20, 32'h55, 0, 0);
        tbl[10] = mk(0, 1, 32'h20, 0,      0, 32'h55, 1, 0, 1, 32'h20, 0,    0, 0);
        tbl[11] = mk(0, 1, 32'h20, 0,      0, 0,    0, 0, 0, 0,     0,     1, 32'h55);
        tbl[12] = mk(0, 0, 32'h0,  0,      0, 0,    0, 0, 0, 0,     0,     1, 32'h55);

        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1, 0);
        check("reset s_waitrequest", s_waitrequest, 1);
        check("reset m_read", m_read, 0);
        check("reset m_write", m_write, 0);
        check("reset timeout", timeout, 0);
        check("reset s_readdata", s_readdata, 0);

        for (int i = 0; i < 13; i++) begin
            cycle(0, tbl[i].sw, tbl[i].sr, tbl[i].addr, tbl[i].wdata, tbl[i].mw, tbl[i].mrd);
            if (tbl[i].sw || tbl[i].sr)
                check($sformatf("vec%0d s_waitrequest", i), s_waitrequest, tbl[i].e_sw);
            check($sformatf("vec%0d m_write", i), m_write, tbl[i].e_mwr);
            check($sformatf("vec%0d m_read", i), m_read, tbl[i].e_mrd);
            if (tbl[i].e_mwr || tbl[i].e_mrd)
                check($sformatf("vec%0d m_address", i), m_address, tbl[i].e_maddr);
            if (tbl[i].e_mwr)
                check($sformatf("vec%0d m_writedata", i), m_writedata, tbl[i].e_mwdata);
            if (tbl[i].chk_srd)
                check($sformatf("vec%0d s_readdata", i), s_readdata, tbl[i].e_srd);
        end

        // Reset while a read waits behind a queued write.
        cycle(0, 1, 0, 32'h40, 32'h77, 1, 0);
        check("rst-seq write accepted", s_waitrequest, 0);
        cycle(0, 0, 1, 32'h44, 0, 1, 0);
        cycle(0, 0, 1, 32'h44, 0, 1, 0);
        check("rst-seq read stalled", s_waitrequest, 1);
        cycle(1, 0, 1, 32'h44, 0, 1, 0);
        check("rst-seq in-reset m_write", m_write, 0);
        check("rst-seq in-reset m_read", m_read, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("rst-seq after m_write", m_write, 0);
        check("rst-seq after m_read", m_read, 0);
        check("rst-seq after s_waitrequest", s_waitrequest, 1);
        check("rst-seq after s_readdata", s_readdata, 0);
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            if (m_read || m_write) lows++;
        end
        check("rst-seq no stale master cmds", lows, 0);
        cycle(0, 1, 0, 32'h48, 32'h99, 0, 0);
        check("rst-seq idle write accepted", s_waitrequest, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("rst-seq write latency", m_write, 1);
        check("rst-seq write addr", m_address, 32'h48);

        // Read against a master that never answers.
        cycle(0, 0, 1, 32'h60, 0, 1, 0);
`ifdef AMM2AMM_PIPE_TIMEOUT_EN
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle(0, 0, 1, 32'h60, 0, 1, 32'h1234);
            if (!s_waitrequest) found = 1;
        end
        check("timeout read completes", found, 1);
        check("timeout pulse", timeout, 1);
        check("timeout readdata", s_readdata, 32'hFFFF_FFFF);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("timeout pulse width", timeout, 0);
        check("timeout master idle", m_read, 0);
`else
        lows = 0; pulses = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(0, 0, 1, 32'h60, 0, 1, 32'h1234);
            if (!s_waitrequest) lows++;
            if (timeout) pulses++;
        end
        check("no-timeout read keeps stalling", lows, 0);
        check("no-timeout pulse absent", pulses, 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin ref_mem[i] = 0; slv_mem[i] = 0; end
        pend = 0; pend_age = 0; stall_run = 0;
        for (int i = 0; i < 3200; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            if (!pend) begin
                s_write = 0; s_read = 0;
                if (i < 3000) begin
                    r   = $urandom_range(0, 99);
                    up  = $urandom();
                    idx = $urandom_range(0, 7);
                    s_address    = {up[31:5], idx[2:0], 2'b00};
                    s_writedata  = $urandom();
                    s_byteenable = 4'($urandom_range(0, 15));
                    s_write      = (r < 45);
                    s_read       = (r >= 45 && r < 70);
                    if (s_write || s_read) begin pend = 1; pend_age = 0; end
                    if (s_read) begin
                        cmd.rd = 1; cmd.addr = s_address; cmd.wdata = s_writedata;
                        cmd.be = s_byteenable;
                        exp_q.push_back(cmd);
                    end
                end
            end
            m_waitrequest = (stall_run < 3) && ($urandom_range(0, 2) == 0);
            stall_run = m_waitrequest ? stall_run + 1 : 0;
            #1 m_readdata = slv_mem[m_address[4:2]];
            @(negedge clk);
            if ((m_read || m_write) && !m_waitrequest) begin
                if (exp_q.size() == 0) begin
                    check("rand unexpected master cmd", 1, 0);
                end else begin
                    got = exp_q.pop_front();
                    check("rand master cmd type", m_read, got.rd);
                    check("rand master address", m_address, got.addr);
                    check("rand master byteenable", m_byteenable, got.be);
                    if (!got.rd) check("rand master writedata", m_writedata, got.wdata);
                end
                if (m_write) slv_mem[m_address[4:2]] = m_writedata;
            end
            if (s_write && !s_waitrequest) begin
                cmd.rd = 0; cmd.addr = s_address; cmd.wdata = s_writedata; cmd.be = s_byteenable;
                exp_q.push_back(cmd);
                ref_mem[s_address[4:2]] = s_writedata;
                pend = 0;
            end
            if (s_read && !s_waitrequest) begin
                check("rand read data", s_readdata, ref_mem[s_address[4:2]]);
                pend = 0;
            end
            if (pend) begin
                pend_age++;
                if (pend_age > 100) begin
                    check("rand slave stall bound", pend_age, 0);
                    pend = 0;
                end
            end
        end
        check("rand queue drained", exp_q.size(), 0);
        check("rand no pending slave cmd", pend, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
